// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus signals for apb_master_bridge.
// master = bridge side; slave = requester and APB completer side (bench or host).
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               paddr, pwrite, pwdata, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               paddr, pwrite, pwdata, psel, penable
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to single APB SETUP/ACCESS transfer, one-cycle response strobe.
// Optional ACCESS wait-state timeout: define APB_MASTER_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 pclk,
    input  logic                 prst_n,
    apb_master_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  pwrite_q, psel_q, penable_q, rsp_valid_q, rsp_err_q;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] tocnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state       <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            tocnt       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr_q   <= bus.cmd_addr;
                        pwdata_q  <= bus.cmd_wdata;
                        pwrite_q  <= bus.cmd_write;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                    tocnt     <= '0;
`endif
                end
                ACCESS: begin
                    // pready wins over a timeout landing on the same edge
                    if (bus.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
                        state       <= IDLE;
                    end
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                    else if (tocnt == TO_W'(TIMEOUT_CYCLES)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state       <= IDLE;
                    end else begin
                        tocnt <= tocnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed + randomized bench for apb_master_bridge; the bench plays requester and an APB memory slave.
module tb_apb_master_bridge;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic pclk   = 1'b0;
    logic prst_n = 1'b0;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk  (pclk),
        .prst_n(prst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] last_rd;
    logic          last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic slave_idle();
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata  = DW'($urandom);
    endtask

    // One transfer from an IDLE negedge to the completion negedge (rsp_valid cycle).
    task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input bit err, input bit poke);
        logic [DW-1:0] rd;
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        if (poke) begin
            bus.cmd_addr  = 8'h10;
            bus.cmd_write = 1'b0;
        end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_wdata = DW'($urandom);
            bus.cmd_write = 1'($urandom);
        end
        chk("setup_psel", bus.psel, 1);
        chk("setup_penable", bus.penable, 0);
        chk("setup_paddr", bus.paddr, a);
        chk("setup_pwrite", bus.pwrite, wr);
        if (wr) chk("setup_pwdata", bus.pwdata, d);
        chk("setup_cmd_ready", bus.cmd_ready, 0);
        chk("setup_busy", bus.busy, 1);
        chk("setup_rsp_valid", bus.rsp_valid, 0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("access_psel", bus.psel, 1);
        chk("access_penable", bus.penable, 1);
        chk("access_paddr", bus.paddr, a);
        for (int i = 0; i < waits; i++) begin
            slave_idle();
            tick();
            chk("wait_penable", bus.penable, 1);
            chk("wait_paddr", bus.paddr, a);
            chk("wait_rsp_valid", bus.rsp_valid, 0);
        end
        rd = (wr || err) ? DW'($urandom) : mem[a];
        bus.pready  = 1'b1;
        bus.pslverr = err;
        bus.prdata  = rd;
        tick();
        slave_idle();
        if (wr && !err) mem[a] = d;
        last_rd  = wr ? '0 : rd;
        last_err = err;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_err", bus.rsp_err, err);
        chk("rsp_rdata", bus.rsp_rdata, last_rd);
        chk("done_psel", bus.psel, 0);
        chk("done_penable", bus.penable, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_paddr_held", bus.paddr, a);
        chk("done_pwrite_held", bus.pwrite, wr);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("gap_rsp_valid", bus.rsp_valid, 0);
            chk("gap_rdata_held", bus.rsp_rdata, last_rd);
            chk("gap_err_held", bus.rsp_err, last_err);
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        prst_n = 1'b0;
        tick();
        prst_n = 1'b1;
        tick();
        last_rd  = '0;
        last_err = 1'b0;
    endtask

    initial begin
        int seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);

        // reset state
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        prst_n = 1'b1;
        tick();
        last_rd  = '0;
        last_err = 1'b0;

        // write then read, zero wait; back-to-back accept in the rsp_valid cycle
        do_xfer(1'b1, 8'h05, 8'hA5, 0, 1'b0, 1'b0);
        do_xfer(1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b0);
        chk("readback_a5", bus.rsp_rdata, 8'hA5);
        gap(1);
        // three wait states
        do_xfer(1'b0, 8'h3C, 8'h00, 3, 1'b0, 1'b0);
        gap(2);
        // slave error on write, then a clean transfer
        do_xfer(1'b1, 8'hFF, 8'h77, 1, 1'b1, 1'b0);
        chk("err_rdata_zero", bus.rsp_rdata, 0);
        gap(1);
        do_xfer(1'b0, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
        // command presented while busy is ignored
        do_xfer(1'b1, 8'h20, 8'h5A, 2, 1'b0, 1'b1);
        gap(1);
        do_xfer(1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0);

        // randomized traffic against the memory model
        for (int k = 0; k < 40; k++) begin
            do_xfer(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 9) == 0), 1'b0);
            gap(int'($urandom_range(0, 2)));
        end

        // reset mid-ACCESS drops the bus asynchronously
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h22;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("pre_rst_penable", bus.penable, 1);
        #1 prst_n = 1'b0;
        #1;
        chk("async_psel", bus.psel, 0);
        chk("async_penable", bus.penable, 0);
        chk("async_rsp_valid", bus.rsp_valid, 0);
        chk("async_cmd_ready", bus.cmd_ready, 1);
        @(negedge pclk);
        tick();
        prst_n = 1'b1;
        tick();
        chk("post_rst_rsp_valid", bus.rsp_valid, 0);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        last_rd  = '0;
        last_err = 1'b0;

        // pready stuck low
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h3C;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        repeat (TO) tick();
        chk("to_still_waiting", bus.penable, 1);
        chk("to_no_rsp_yet", bus.rsp_valid, 0);
        tick();
        chk("to_rsp_valid", bus.rsp_valid, 1);
        chk("to_rsp_err", bus.rsp_err, 1);
        chk("to_rsp_rdata", bus.rsp_rdata, 0);
        chk("to_psel", bus.psel, 0);
`else
        seen = 0;
        repeat (120) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        chk("stall_no_rsp", seen, 0);
        chk("stall_penable", bus.penable, 1);
        chk("stall_psel", bus.psel, 1);
`endif
        do_reset();
        do_xfer(1'b0, 8'h05, 8'h00, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB requester that drives the existing APB memory slave (and any APB3 completer) from a simple valid/ready command port. It converts one command into one APB SETUP→ACCESS transfer and waits out slave wait states. It returns read data and error status on a one-cycle response strobe. It replaces hand-driven psel/penable sequences in benches and gives future host logic a clean way to reach the memory.

Parameters:
ADDR_WIDTH, 8, width of paddr and cmd_addr
DATA_WIDTH, 8, width of pwdata/prdata and the command/response data
TIMEOUT_CYCLES, 16, ACCESS cycles with pready low before abort (used only with the optional feature)

Ports:
pclk  input  1  APB clock; all logic on its rising edge
prst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  bridge can accept a command (high only in IDLE)
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  pslverr or timeout for this transfer
busy  output  1  high in SETUP or ACCESS
paddr  output  ADDR_WIDTH  APB address
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
psel  output  1  APB select
penable  output  1  APB enable
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset (prst_n low, async): state IDLE. psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and the timeout counter are all 0. cmd_ready=1, busy=0. psel/penable drop immediately, even mid-transfer; no response is issued for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On an edge with cmd_valid=1:
  - register cmd_addr→paddr, cmd_wdata→pwdata, cmd_write→pwrite
  - psel←1, penable←0, go to SETUP.
- SETUP: exactly one cycle. penable←1, go to ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwdata/pwrite stay stable.
  - Edge with pready=0: stay in ACCESS (wait state).
  - Edge with pready=1: psel←0, penable←0, rsp_valid←1, rsp_err←pslverr, go to IDLE.
  - rsp_rdata←prdata for reads; rsp_rdata←0 for writes.
- rsp_valid is high for exactly one cycle (the first IDLE cycle). rsp_rdata and rsp_err hold until the next response.
- Latency: the command edge opens SETUP; the first possible completion edge is the 2nd edge after the command; rsp_valid is seen in the following cycle. Zero-wait transfers accept a new command every 3 cycles minimum.
- cmd_valid while busy: ignored, not queued. The requester must hold cmd_valid until cmd_ready. A command can be accepted in the same cycle rsp_valid is high.
- paddr/pwdata/pwrite keep their last values after the transfer ends; there is no glitch back to 0.
- pslverr is sampled only on the completion edge and ignored in every other cycle.
- Address and data are passed through unchanged. No alignment or range check is done; range errors are the slave's job via pslverr.

Optional Feature:
Macro: APB_MASTER_BRIDGE_TIMEOUT_EN
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES)+1) clears on SETUP→ACCESS and increments on each ACCESS edge with pready=0.
  - If the counter equals TIMEOUT_CYCLES on an edge with pready still 0: abort the transfer. psel←0, penable←0, rsp_valid←1, rsp_err←1, rsp_rdata←0, go to IDLE.
  - A pready=1 on that same edge wins over the timeout; normal completion applies.
- Undefined: no counter exists and ACCESS waits indefinitely for pready.

Test Plan:
- Write then read, pready tied to 1: write addr 0x05 data 0xA5, then read addr 0x05 → APB trace IDLE/SETUP/ACCESS per transfer, each rsp_valid one cycle, read rsp_rdata=0xA5, rsp_err=0.
- Wait states: pready held low 3 edges in ACCESS for a read of 0x3C → penable high 4 cycles, paddr stable at 0x3C throughout, rsp_valid 1 cycle after pready rises.
- Slave error: write addr 0xFF with pslverr=1 on the completion edge → rsp_err=1, rsp_rdata=0x00. The next clean transfer returns rsp_err=0.
- Busy handling: pulse a second command (addr 0x10) during SETUP → cmd_ready=0 and the command is not accepted. Holding it until IDLE starts its SETUP on the edge after cmd_ready returns.
- Reset mid-ACCESS: drop prst_n while penable=1 → psel/penable go to 0 without waiting for a clock edge, no rsp_valid, cmd_ready=1 after reset release.
- Timeout (macro defined, TIMEOUT_CYCLES=16): pready stuck at 0 → abort after 16 wait edges, rsp_valid with rsp_err=1 and rsp_rdata=0. With the macro undefined, the same stimulus stays in ACCESS for 100+ cycles with no response.
